clkdiv_sched: RTL and testbench

Owns the 8-bit divider counter and the tap select, and produces a glitch-free divided clock (dclk_o).
Two requesters may ask for a new divide ratio. A round-robin arbiter accepts one request at a time.
The select change is applied only at counter wrap (0xFF -> 0x00), where every tap falls together. Downstream timing blocks get a clean divided clock with no runt pulses.

---
 rtl/clkdiv_pkg.sv | 36 +++
 rtl/clkdiv_sched_rr_arb2.sv | 31 +++
 rtl/clkdiv_sched.sv | 136 +++++++++++++
 tb/tb_clkdiv_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg
// Shared definitions for the divided-clock scheduler:
//   - select encodings (which counter tap drives the divided clock)
//   - FSM state type
//   - tap_sel(): picks one of the four top counter bits for a given select
// ---------------------------------------------------------------------------
package clkdiv_pkg;

    // Number of counter MSBs that can be tapped for the divided clock.
    localparam int TAP_BITS = 4;

    localparam logic [1:0] SEL_DIV256 = 2'b00;
    localparam logic [1:0] SEL_DIV128 = 2'b01;
    localparam logic [1:0] SEL_DIV64  = 2'b10;
    localparam logic [1:0] SEL_DIV32  = 2'b11;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_WRAP = 1'b1
    } state_t;

    // top holds cnt[CNT_W-1 -: 4]; top[3] is the MSB (slowest tap).
    function automatic logic tap_sel(input logic [TAP_BITS-1:0] top,
                                     input logic [1:0]          sel);
        logic bit_r;
        case (sel)
            SEL_DIV256: bit_r = top[3];
            SEL_DIV128: bit_r = top[2];
            SEL_DIV64:  bit_r = top[1];
            default:    bit_r = top[0];
        endcase
        return bit_r;
    endfunction

endpackage

// File: rtl/clkdiv_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req_i        in  2  request vector (bit n = requester n)
//   en_i         in  1  grant enable; no grant is issued while low
//   last_grant_i in  1  index of the requester granted most recently
//   gnt_o        out 2  one-hot grant (all zero when nothing granted)
// ---------------------------------------------------------------------------
module rr_arb2
    import clkdiv_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                // Both asking: the one not served last time wins.
                gnt_o = last_grant_i ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
    end

endmodule

// File: rtl/clkdiv_sched.sv
// ---------------------------------------------------------------------------
// clkdiv_sched
// Free-running divider counter with a selectable tap producing a registered,
// glitch-free divided clock. Two requesters ask for new ratios through a
// round-robin arbiter; an accepted change is held pending and applied only
// at counter wrap (all-ones -> zero), where every tap is low together, so the
// divided clock never shows a runt pulse.
// Ports:
//   clk_i   in  1  system clock
//   rst_i   in  1  asynchronous active-high reset
//   req0_i  in  1  requester 0 ratio-change request (held until acked)
//   sel0_i  in  2  requester 0 target select
//   req1_i  in  1  requester 1 ratio-change request (held until acked)
//   sel1_i  in  2  requester 1 target select
//   ack0_o  out 1  requester 0 accepted (same cycle as the grant)
//   ack1_o  out 1  requester 1 accepted (same cycle as the grant)
//   busy_o  out 1  a change is pending (waiting for wrap)
//   done_o  out 1  one-cycle pulse: newly requested select is in effect
//   sel_o   out 2  select currently driving dclk_o
//   dclk_o  out 1  divided clock (flop output)
// ---------------------------------------------------------------------------
module clkdiv_sched
    import clkdiv_pkg::*;
#(
    parameter int         CNT_W   = 8,
    parameter logic [1:0] RST_SEL = SEL_DIV256
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_i,
    input  logic [1:0] sel0_i,
    input  logic       req1_i,
    input  logic [1:0] sel1_i,
    output logic       ack0_o,
    output logic       ack1_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] sel_o,
    output logic       dclk_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       sel_q,   sel_d;
    logic [1:0]       pend_q,  pend_d;
    logic             last_q,  last_d;
    logic             dclk_q,  dclk_d;
    logic             done_q,  done_d;

    logic       grant_en;
    logic [1:0] gnt;
    logic [1:0] win_sel;

    // Grants only in IDLE; also masked while reset is asserted so the
    // acks read as zero for the whole reset window, not just after it.
    assign grant_en = (state_q == IDLE) && !rst_i;

    rr_arb2 u_arb (
        .req_i        ({req1_i, req0_i}),
        .en_i         (grant_en),
        .last_grant_i (last_q),
        .gnt_o        (gnt)
    );

    assign win_sel = gnt[1] ? sel1_i : sel0_i;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        last_d  = last_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    pend_d = win_sel;
                    last_d = gnt[1];
                    if (win_sel == sel_q) begin
                        // Nothing to switch; confirm right away.
                        done_d = 1'b1;
                    end else begin
                        // Even when granted at cnt == max, the switch is
                        // only evaluated from WAIT_WRAP, so that wrap is
                        // skipped and the next full wrap is used.
                        state_d = WAIT_WRAP;
                    end
                end
            end
            WAIT_WRAP: begin
                if (cnt_q == CNT_MAX) begin
                    sel_d   = pend_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Tap is taken from next-state counter and select so the flop
        // output lines up with cnt_q; at wrap the new tap starts from 0.
        dclk_d = tap_sel(cnt_d[CNT_W-1 -: TAP_BITS], sel_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= RST_SEL;
            pend_q  <= RST_SEL;
            last_q  <= 1'b1;
            dclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            dclk_q  <= dclk_d;
            done_q  <= done_d;
        end
    end

    assign ack0_o = gnt[0];
    assign ack1_o = gnt[1];
    assign busy_o = (state_q == WAIT_WRAP);
    assign done_o = done_q;
    assign sel_o  = sel_q;
    assign dclk_o = dclk_q;

endmodule

// File: tb/tb_clkdiv_sched.sv
module tb_clkdiv_sched;

    logic       clk_i  = 1'b0;
    logic       rst_i  = 1'b1;
    logic       req0_i = 1'b0;
    logic [1:0] sel0_i = 2'b00;
    logic       req1_i = 1'b0;
    logic [1:0] sel1_i = 2'b00;
    logic       ack0_o, ack1_o, busy_o, done_o, dclk_o;
    logic [1:0] sel_o;

    clkdiv_sched #(.CNT_W(8), .RST_SEL(2'b00)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req0_i (req0_i),
        .sel0_i (sel0_i),
        .req1_i (req1_i),
        .sel1_i (sel1_i),
        .ack0_o (ack0_o),
        .ack1_o (ack1_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .sel_o  (sel_o),
        .dclk_o (dclk_o)
    );

    always #5 clk_i = ~clk_i;

    int ntests = 0;
    int nfail  = 0;

    // Reference state, advanced once per clock edge by tick().
    logic [7:0] cnt_m;
    logic [1:0] m_sel, m_pend, g_sel;
    logic       m_wait, m_done, m_last, g_valid;
    logic [1:0] sb[$];   // selects expected to take effect, in order

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tap_m(input logic [7:0] c, input logic [1:0] s);
        case (s)
            2'b00:   return c[7];
            2'b01:   return c[6];
            2'b10:   return c[5];
            default: return c[4];
        endcase
    endfunction

    function automatic logic [1:0] exp_rr(input logic r0, input logic r1);
        if (m_wait)     return 2'b00;
        if (r0 && r1)   return m_last ? 2'b01 : 2'b10;
        return {r1, r0};
    endfunction

    task automatic model_reset();
        cnt_m = 8'd0; m_sel = 2'b00; m_pend = 2'b00; m_wait = 1'b0;
        m_done = 1'b0; m_last = 1'b1; g_valid = 1'b0; g_sel = 2'b00;
        sb.delete();
    endtask

    // One clock: update the reference at the edge, then check outputs #1 later.
    task automatic tick();
        logic [7:0] c_prev;
        logic [1:0] e_sel;
        c_prev = cnt_m;
        @(posedge clk_i);
        cnt_m  = c_prev + 8'd1;
        m_done = 1'b0;
        if (m_wait && c_prev == 8'hFF) begin
            m_sel = m_pend; m_wait = 1'b0; m_done = 1'b1;
        end else if (g_valid) begin
            m_pend = g_sel;
            if (g_sel == m_sel) m_done = 1'b1;
            else                m_wait = 1'b1;
        end
        g_valid = 1'b0;
        #1;
        check("dclk", {15'd0, dclk_o}, {15'd0, tap_m(cnt_m, m_sel)});
        check("busy", {15'd0, busy_o}, {15'd0, m_wait});
        check("done", {15'd0, done_o}, {15'd0, m_done});
        check("sel",  {14'd0, sel_o},  {14'd0, m_sel});
        if (done_o) begin
            check("sb_nonempty", {15'd0, (sb.size() != 0)}, 16'd1);
            if (sb.size() != 0) begin
                e_sel = sb.pop_front();
                check("sb_sel", {14'd0, sel_o}, {14'd0, e_sel});
            end
        end
    endtask

    // Drive requests, check the same-cycle acks, record a grant, clock once.
    task automatic drive_req(input logic r0, input logic [1:0] s0,
                             input logic r1, input logic [1:0] s1,
                             input logic [1:0] exp_ack);
        req0_i = r0; sel0_i = s0; req1_i = r1; sel1_i = s1;
        #1;
        check("ack0", {15'd0, ack0_o}, {15'd0, exp_ack[0]});
        check("ack1", {15'd0, ack1_o}, {15'd0, exp_ack[1]});
        if (exp_ack != 2'b00) begin
            g_valid = 1'b1;
            g_sel   = exp_ack[1] ? s1 : s0;
            m_last  = exp_ack[1];
            sb.push_back(g_sel);
        end
        tick();
    endtask

    initial begin
        int first_rise;
        int grants;
        int n;

        // Reset state, with both requests high to confirm acks stay low.
        model_reset();
        rst_i = 1'b1; req0_i = 1'b1; req1_i = 1'b1; sel0_i = 2'b11; sel1_i = 2'b10;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_sel",  {14'd0, sel_o},  16'd0);
        check("rst_dclk", {15'd0, dclk_o}, 16'd0);
        check("rst_busy", {15'd0, busy_o}, 16'd0);
        check("rst_done", {15'd0, done_o}, 16'd0);
        check("rst_ack0", {15'd0, ack0_o}, 16'd0);
        check("rst_ack1", {15'd0, ack1_o}, 16'd0);
        req0_i = 1'b0; req1_i = 1'b0;
        rst_i  = 1'b0;

        // Reset release: 300 idle cycles, divide-by-256, first rise at 128.
        first_rise = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            check("idle_acks", {14'd0, ack1_o, ack0_o}, 16'd0);
            if (dclk_o && first_rise == 0) first_rise = i + 1;
        end
        check("first_rise", first_rise[15:0], 16'd128);

        // Single change: req0 -> 11 at cnt = 0x10.
        for (int i = 0; i < 300 && cnt_m != 8'h10; i++) tick();
        check("t2_at_10", {8'd0, cnt_m}, 16'h0010);
        drive_req(1'b1, 2'b11, 1'b0, 2'b00, exp_rr(1'b1, 1'b0));
        req0_i = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_o) break;
        end
        check("t2_done_seen", {15'd0, done_o}, 16'd1);
        check("t2_sel", {14'd0, sel_o}, 16'd3);
        repeat (100) tick();

        // Same select from requester 1: immediate done, never busy.
        drive_req(1'b0, 2'b00, 1'b1, 2'b11, exp_rr(1'b0, 1'b1));
        req1_i = 1'b0;
        tick();
        repeat (20) tick();

        // Contention: both held high; winners must alternate 0,1,0,1.
        grants = 0;
        for (int c = 0; c < 1500 && grants < 4; c++) begin
            req0_i = 1'b1; sel0_i = 2'b01; req1_i = 1'b1; sel1_i = 2'b10;
            #1;
            if (!m_wait) begin
                check("rr_win", {14'd0, ack1_o, ack0_o},
                      (grants % 2 == 0) ? 16'd1 : 16'd2);
                grants++;
            end
            drive_req(1'b1, 2'b01, 1'b1, 2'b10, exp_rr(1'b1, 1'b1));
        end
        check("rr_grants", grants[15:0], 16'd4);
        req0_i = 1'b0; req1_i = 1'b0;
        for (int i = 0; i < 300 && m_wait; i++) tick();
        tick();

        // Wrap coincidence: accepted at cnt = 0xFF, switch 257 edges later.
        for (int i = 0; i < 300 && cnt_m != 8'hFF; i++) tick();
        check("t5_at_ff", {8'd0, cnt_m}, 16'h00FF);
        drive_req(1'b1, 2'b01, 1'b0, 2'b00, exp_rr(1'b1, 1'b0));
        req0_i = 1'b0;
        n = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            if (sel_o == 2'b01) break;
        end
        check("wrap_lat", n[15:0], 16'd257);
        repeat (5) tick();

        // Reset mid-wait: pending change discarded, no done afterwards.
        drive_req(1'b0, 2'b00, 1'b1, 2'b11, exp_rr(1'b0, 1'b1));
        req1_i = 1'b0;
        repeat (5) tick();
        check("t6_busy_before", {15'd0, busy_o}, 16'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_rst_busy", {15'd0, busy_o}, 16'd0);
        check("t6_rst_sel",  {14'd0, sel_o},  16'd0);
        check("t6_rst_dclk", {15'd0, dclk_o}, 16'd0);
        check("t6_rst_done", {15'd0, done_o}, 16'd0);
        check("t6_rst_acks", {14'd0, ack1_o, ack0_o}, 16'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        repeat (300) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
